alu_cmd_deser: RTL and testbench
================================

Name: alu_cmd_deser

Overview:
- Upstream feeder for the 3-bit ALU (operands a, b; opcode select c; 4-bit result).
- Receives bit-serial command frames, assembles the a, b and c fields, and presents them as one parallel command word.
- Uses a valid/ready handshake so the ALU stage sees operands that are held stable until consumed.
- Replaces plusarg-driven operand setup when commands are streamed in over one wire.

Parameters:
- OPW, 3, width of each operand field (a, b).
- SELW, 3, width of opcode select field (c).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ser_in  in  1  serial data bit, sampled only when ser_valid=1.
- ser_valid  in  1  bit strobe; one bit consumed per cycle it is high.
- a_out  out  OPW  operand a to ALU.
- b_out  out  OPW  operand b to ALU.
- c_out  out  SELW  opcode select to ALU.
- cmd_valid  out  1  command word valid.
- cmd_ready  in  1  ALU stage accepts the command.
- busy  out  1  high while a frame is in progress (DATA or STOP).
- frame_err  out  1  one-cycle pulse on bad stop bit.
- overrun  out  1  one-cycle pulse when a bit is dropped in HOLD.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; a_out, b_out, c_out=0; cmd_valid, busy, frame_err, overrun=0; bit counter=0.
- Frame format: start bit '1', then N=2*OPW+SELW data bits, then stop bit '0'. N=9 at defaults.
- Data bit order: a MSB-first, then b MSB-first, then c MSB-first.
- Only cycles with ser_valid=1 advance the frame. Gaps of any length between strobes are legal and change no state.
- FSM states and transitions:
  - IDLE: strobe with ser_in=1 goes to DATA with counter=0. Strobe with ser_in=0 is ignored (line idle).
  - DATA: each strobe shifts ser_in into a 9-bit shift register. When the counter reaches N-1 on a strobe, go to STOP.
  - STOP: a strobe with ser_in=0 loads a_out, b_out, c_out from the shift register, sets cmd_valid=1 and goes to HOLD. A strobe with ser_in=1 pulses frame_err for one cycle and goes to IDLE; outputs and cmd_valid are unchanged.
  - HOLD: cmd_valid=1 and a_out, b_out, c_out are held stable. A transfer occurs on a clock edge with cmd_valid and cmd_ready both high; cmd_valid falls in the following cycle.
- Latency: cmd_valid rises in the cycle after the stop-bit edge. The outputs become valid in that same cycle.
- Simultaneous events in HOLD:
  - Transfer in a cycle with a strobe and ser_in=1: the start bit is accepted and the FSM goes directly to DATA, giving back-to-back throughput.
  - Transfer with a strobe and ser_in=0: the strobe is treated as idle and the FSM goes to IDLE.
  - No transfer with a strobe: overrun pulses for one cycle, the bit is dropped, and the FSM stays in HOLD.
- Operand registers keep their last value after a transfer. Only a good stop bit overwrites them.
- busy=1 in DATA and STOP, 0 in IDLE and HOLD.
- Reset asserted mid-frame or in HOLD: the partial frame or pending command is discarded and all outputs return to reset values immediately (asynchronous).
- cmd_ready while cmd_valid=0 is ignored.
- Counter width is clog2(N). It never wraps past N-1; it is cleared on entry to DATA.

Decomposition:
- Shared package or header (alu_defs):
  - OPW and SELW defaults.
  - FRAME_DATA_BITS = 2*OPW+SELW.
  - State encoding localparams: IDLE=2'd0, DATA=2'd1, STOP=2'd2, HOLD=2'd3.
- One natural sub-module, alu_shift_in: an N-bit serial-in/parallel-out shift register with enable, asynchronous active-low clear, and a parallel output.
- The FSM, counter and output registers live in alu_cmd_deser.

Test Plan:
- Frame 1_101_011_010_0 with back-to-back strobes and cmd_ready=1 -> one cycle after the stop bit: a_out=5, b_out=3, c_out=2, cmd_valid=1 for exactly 1 cycle, busy=0.
- Same frame with cmd_ready=0 for 4 cycles, then 1 -> cmd_valid and a, b, c held stable through all 5 cycles. Two extra strobes during the stall -> overrun pulses twice, outputs unchanged.
- Frame 1_111_000_001 with stop bit 1 -> frame_err pulses once, cmd_valid stays 0, a, b, c keep their prior values. The next frame 1_010_010_111_0 yields a=2, b=2, c=7.
- Frame a=7, b=7, c=0 sent with ser_valid alternating 1/0 and random gaps up to 5 cycles -> identical result to the back-to-back case; busy high from start bit to stop bit.
- Two frames back-to-back, with the second start bit strobed in the transfer cycle of the first (cmd_ready=1) -> both commands delivered: (5,3,2) then (1,6,4), no overrun.
- rst_n pulsed low mid-DATA after 4 data bits -> all outputs 0 asynchronously. A full frame sent afterwards is decoded correctly and the stale bits are not observed.

Source files
------------

// File: rtl/alu_defs.sv
// Shared widths and FSM encoding for the serial command deserializer feeding the 3-bit ALU.
package alu_defs;

  localparam int OPW_DEF  = 3;
  localparam int SELW_DEF = 3;

  function automatic int frame_data_bits(input int opw, input int selw);
    return 2 * opw + selw;
  endfunction

  localparam int FRAME_DATA_BITS = frame_data_bits(OPW_DEF, SELW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/alu_shift_in.sv
// Serial-in/parallel-out shift register; the newest bit enters at the LSB so the
// first bit received ends up in the MSB.
module alu_shift_in #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en_i,
  input  logic         bit_i,
  output logic [N-1:0] data_o
);

  logic [N-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (shift_en_i) begin
      sr_q <= {sr_q[N-2:0], bit_i};
    end
  end

  assign data_o = sr_q;

endmodule

// File: rtl/alu_cmd_deser.sv
// Assembles bit-serial frames (start '1', a, b, c MSB-first, stop '0') into one
// parallel ALU command word presented with a valid/ready handshake.
module alu_cmd_deser
  import alu_defs::*;
#(
  parameter int OPW  = OPW_DEF,
  parameter int SELW = SELW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ser_in,
  input  logic            ser_valid,
  output logic [OPW-1:0]  a_out,
  output logic [OPW-1:0]  b_out,
  output logic [SELW-1:0] c_out,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun
);

  localparam int N    = frame_data_bits(OPW, SELW);
  localparam int CNTW = $clog2(N);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [SELW-1:0] c_q;
  logic            valid_q, busy_q, ferr_q, ovr_q;
  logic            shift_en_d;
  logic [N-1:0]    frame_bits;

  assign shift_en_d = ser_valid && (state_q == DATA);

  alu_shift_in #(.N(N)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (shift_en_d),
    .bit_i      (ser_in),
    .data_o     (frame_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ser_valid && ser_in) begin
            state_q <= DATA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DATA: begin
          if (ser_valid) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= STOP;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        STOP: begin
          if (ser_valid) begin
            busy_q <= 1'b0;
            if (!ser_in) begin
              a_q     <= frame_bits[N-1 -: OPW];
              b_q     <= frame_bits[N-1-OPW -: OPW];
              c_q     <= frame_bits[SELW-1:0];
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          // A start bit arriving in the transfer cycle opens the next frame at once.
          if (cmd_ready) begin
            valid_q <= 1'b0;
            if (ser_valid && ser_in) begin
              state_q <= DATA;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (ser_valid) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign c_out     = c_q;
  assign cmd_valid = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_alu_cmd_deser.sv
// Directed plus randomized bench for alu_cmd_deser with a transaction-level scoreboard.
module tb_alu_cmd_deser;

  logic       clk = 1'b0;
  logic       rst_n, ser_in, ser_valid, cmd_ready;
  logic [2:0] a_out, b_out, c_out;
  logic       cmd_valid, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;
  bit rand_ready = 1'b0;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  alu_cmd_deser dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so the falling edge sees what the next rising edge will.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) obs_q.push_back({a_out, b_out, c_out});
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic gap(input int maxg);
    repeat ($urandom_range(0, maxg)) tick();
  endtask

  // Sends {a,b,c} MSB-first framed by start/stop bits, optional random gaps between strobes.
  task automatic send_frame(input logic [8:0] w, input logic stop_b, input int maxg,
                            input bit chk_busy, input bit with_start);
    if (with_start) begin
      strobe(1'b1);
      if (chk_busy) chk("busy_start", busy, 1);
      gap(maxg);
    end
    for (int i = 8; i >= 0; i--) begin
      strobe(w[i]);
      if (chk_busy) chk("busy_data", busy, 1);
      gap(maxg);
      if (chk_busy) chk("busy_gap", busy, 1);
    end
    strobe(stop_b);
    if (chk_busy) chk("busy_after_stop", busy, 0);
  endtask

  task automatic chk_cmd(input string tag, input logic [2:0] ea, input logic [2:0] eb,
                         input logic [2:0] ec, input logic ev);
    chk({tag, "_a"}, a_out, ea);
    chk({tag, "_b"}, b_out, eb);
    chk({tag, "_c"}, c_out, ec);
    chk({tag, "_valid"}, cmd_valid, ev);
  endtask

  task automatic drain(input string tag);
    while (obs_q.size() > 0 && exp_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    chk({tag, "_extra"}, obs_q.size(), 0);
    chk({tag, "_missing"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, ferr0, exp_ferr, t;
    logic [2:0] ra, rb, rc;
    bit bad;

    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; cmd_ready = 1'b0;
    repeat (2) tick();
    chk_cmd("reset", 0, 0, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back frame, ready high
    cmd_ready = 1'b1;
    send_frame({3'd5, 3'd3, 3'd2}, 1'b0, 0, 1'b1, 1'b1);
    exp_q.push_back({3'd5, 3'd3, 3'd2});
    chk_cmd("t1", 5, 3, 2, 1);
    tick();
    chk("t1_valid_one_cycle", cmd_valid, 0);
    chk("t1_a_kept", a_out, 5);
    drain("t1_cmd");

    // 2: stall for 4 cycles with two dropped strobes
    cmd_ready = 1'b0;
    ovr0 = ovr_seen;
    send_frame({3'd5, 3'd3, 3'd2}, 1'b0, 0, 1'b0, 1'b1);
    exp_q.push_back({3'd5, 3'd3, 3'd2});
    for (int k = 0; k < 4; k++) begin
      chk_cmd("t2_hold", 5, 3, 2, 1);
      if (k == 1 || k == 2) strobe(1'b1);
      else tick();
    end
    chk_cmd("t2_last", 5, 3, 2, 1);
    cmd_ready = 1'b1;
    tick();
    chk("t2_valid_drop", cmd_valid, 0);
    tick();
    chk("t2_overruns", ovr_seen - ovr0, 2);
    drain("t2_cmd");

    // 3: bad stop bit, then a good frame
    ferr0 = ferr_seen;
    send_frame({3'd7, 3'd0, 3'd1}, 1'b1, 0, 1'b0, 1'b1);
    tick();
    chk("t3_ferr", ferr_seen - ferr0, 1);
    chk_cmd("t3_kept", 5, 3, 2, 0);
    send_frame({3'd2, 3'd2, 3'd7}, 1'b0, 0, 1'b0, 1'b1);
    exp_q.push_back({3'd2, 3'd2, 3'd7});
    chk_cmd("t3_next", 2, 2, 7, 1);
    tick();
    drain("t3_cmd");

    // 4: gapped strobes
    send_frame({3'd7, 3'd7, 3'd0}, 1'b0, 5, 1'b1, 1'b1);
    exp_q.push_back({3'd7, 3'd7, 3'd0});
    chk_cmd("t4", 7, 7, 0, 1);
    tick();
    drain("t4_cmd");

    // 5: second start bit in the transfer cycle of the first command
    ovr0 = ovr_seen;
    send_frame({3'd5, 3'd3, 3'd2}, 1'b0, 0, 1'b0, 1'b1);
    exp_q.push_back({3'd5, 3'd3, 3'd2});
    chk_cmd("t5_first", 5, 3, 2, 1);
    strobe(1'b1);
    chk("t5_busy_b2b", busy, 1);
    send_frame({3'd1, 3'd6, 3'd4}, 1'b0, 0, 1'b0, 1'b0);
    exp_q.push_back({3'd1, 3'd6, 3'd4});
    chk_cmd("t5_second", 1, 6, 4, 1);
    tick();
    chk("t5_no_overrun", ovr_seen - ovr0, 0);
    drain("t5_cmd");

    // 6: asynchronous reset after 4 data bits
    strobe(1'b1);
    for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1)));
    #2 rst_n = 1'b0;
    #1;
    chk_cmd("t6_async", 0, 0, 0, 0);
    chk("t6_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame({3'd6, 3'd1, 3'd5}, 1'b0, 0, 1'b1, 1'b1);
    exp_q.push_back({3'd6, 3'd1, 3'd5});
    chk_cmd("t6_after", 6, 1, 5, 1);
    tick();
    drain("t6_cmd");

    // Random frames, random gaps, random ready, occasional bad stop bits
    rand_ready = 1'b1;
    ferr0 = ferr_seen;
    ovr0 = ovr_seen;
    exp_ferr = 0;
    for (int n = 0; n < 30; n++) begin
      ra = 3'($urandom); rb = 3'($urandom); rc = 3'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) strobe(1'b0);
      send_frame({ra, rb, rc}, bad, 3, 1'b0, 1'b1);
      if (bad) exp_ferr++;
      else exp_q.push_back({ra, rb, rc});
      t = 0;
      while (cmd_valid && t < 100) begin
        tick();
        t++;
      end
      chk("rand_drain_in_time", 32'(t < 100), 1);
    end
    rand_ready = 1'b0;
    tick();
    chk("rand_ferr", ferr_seen - ferr0, exp_ferr);
    chk("rand_overrun", ovr_seen - ovr0, 0);
    drain("rand_cmd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
